// File: rtl/sym_odd_fir_serial_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the serial symmetric FIR.
//   state_t        : sequencer states IDLE -> MAC -> DONE
//   fir_out_width  : accumulator/output width that cannot overflow
//   wrap_sub       : (ptr - off) mod depth using compare-and-add only,
//                    so a non-power-of-2 history depth works
package sym_fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int fir_out_width(input int in_w, input int coeff_w, input int n);
        return in_w + coeff_w + $clog2(n) + 1;
    endfunction

    // Both operands are already below depth, so a single conditional add
    // is enough to bring a negative difference back into range.
    function automatic int wrap_sub(input int ptr, input int off, input int depth);
        return (ptr >= off) ? (ptr - off) : (ptr + depth - off);
    endfunction

endpackage

// File: rtl/sym_fir_mac.sv
// Shared arithmetic for one symmetric tap per cycle.
//   clk, rst      : clock, synchronous active-high reset (clears accumulator)
//   i_clr         : zero the accumulator at the start of a sample
//   i_en          : add the current tap product into the accumulator
//   i_a, i_b      : the two mirrored history samples for this tap
//   i_use_b       : 0 on the centre tap, which has no mirror partner
//   i_coeff       : signed coefficient for this tap
//   o_acc         : running sum, OW bits signed
module sym_fir_mac #(
    parameter int IW = 16,
    parameter int CW = 5,
    parameter int OW = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    input  logic signed [IW-1:0] i_a,
    input  logic signed [IW-1:0] i_b,
    input  logic                 i_use_b,
    input  logic signed [CW-1:0] i_coeff,
    output logic signed [OW-1:0] o_acc
);

    localparam int PW = IW + 1 + CW;

    logic signed [IW:0]   w_pre;
    logic signed [PW-1:0] w_prod;
    logic signed [OW-1:0] w_prod_ext;
    logic signed [OW-1:0] r_acc;

    // One guard bit keeps the pre-add exact.
    assign w_pre      = i_use_b ? ({i_a[IW-1], i_a} + {i_b[IW-1], i_b}) : {i_a[IW-1], i_a};
    assign w_prod     = PW'(w_pre) * PW'(i_coeff);
    assign w_prod_ext = OW'(w_prod);

    always_ff @(posedge clk) begin
        if (rst)       r_acc <= '0;
        else if (i_clr) r_acc <= '0;
        else if (i_en)  r_acc <= r_acc + w_prod_ext;
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/sym_odd_fir_serial_ctrl.sv
// Sequencer for a time-multiplexed odd-length symmetric FIR. One shared
// pre-adder + multiplier walks the N_COEFFS unique taps, one per cycle.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, aborts any sample in flight
//   data_in    : signed sample, taken when valid_in && ready_in
//   valid_in   : sample offered
//   ready_in   : high only while idle
//   data_out   : registered signed result
//   valid_out  : one-cycle pulse with data_out
//   busy       : high while computing or presenting a result
module sym_odd_fir_serial_ctrl
    import sym_fir_pkg::*;
#(
    parameter int INPUT_WORD_SIZE = 16,
    parameter int COEFF_WORD_SIZE = 5,
    parameter int N_COEFFS        = 5,
    parameter logic [N_COEFFS*COEFF_WORD_SIZE-1:0] COEFFS =
        (N_COEFFS*COEFF_WORD_SIZE)'(10'h0c1),
    localparam int OUTPUT_WORD_SIZE = fir_out_width(INPUT_WORD_SIZE, COEFF_WORD_SIZE, N_COEFFS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [INPUT_WORD_SIZE-1:0]  data_in,
    input  logic                               valid_in,
    output logic                               ready_in,
    output logic signed [OUTPUT_WORD_SIZE-1:0] data_out,
    output logic                               valid_out,
    output logic                               busy
);

    localparam int IW    = INPUT_WORD_SIZE;
    localparam int CW    = COEFF_WORD_SIZE;
    localparam int OW    = OUTPUT_WORD_SIZE;
    localparam int DEPTH = 2*N_COEFFS - 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int K_W   = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;

    state_t r_state, w_next;

    logic signed [IW-1:0] r_hist [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr, r_base, w_addr_a, w_addr_b;
    logic [K_W-1:0]       r_k;
    logic                 w_accept, w_last, w_mac_clr, w_mac_en;
    logic signed [CW-1:0] w_coeffs [N_COEFFS];
    logic signed [OW-1:0] w_acc, r_data_out;
    logic                 r_valid_out;

    for (genvar g = 0; g < N_COEFFS; g++) begin : g_coeff
        assign w_coeffs[g] = COEFFS[g*CW +: CW];
    end

    // Tap k pairs x[n-k] with its mirror x[n-(DEPTH-1-k)]; base is the
    // slot holding x[n].
    assign w_last   = (r_k == K_W'(N_COEFFS-1));
    assign w_addr_a = PTR_W'(wrap_sub(int'(r_base), int'(r_k), DEPTH));
    assign w_addr_b = PTR_W'(wrap_sub(int'(r_base), DEPTH - 1 - int'(r_k), DEPTH));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        ready_in  = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_mac_clr = 1'b0;
        w_mac_en  = 1'b0;
        case (r_state)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    w_accept  = 1'b1;
                    w_mac_clr = 1'b1;
                    w_next    = MAC;
                end
            end
            MAC: begin
                busy     = 1'b1;
                w_mac_en = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                busy   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_base      <= '0;
            r_k         <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        end else begin
            r_valid_out <= 1'b0;
            if (w_accept) begin
                r_hist[r_wr_ptr] <= data_in;
                r_base           <= r_wr_ptr;
                r_k              <= '0;
            end
            if (w_mac_en && !w_last) r_k <= r_k + K_W'(1);
            if (r_state == DONE) begin
                r_data_out  <= w_acc;
                r_valid_out <= 1'b1;
                r_wr_ptr    <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
        end
    end

    sym_fir_mac #(
        .IW (IW),
        .CW (CW),
        .OW (OW)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_mac_clr),
        .i_en    (w_mac_en),
        .i_a     (r_hist[w_addr_a]),
        .i_b     (r_hist[w_addr_b]),
        .i_use_b (!w_last),
        .i_coeff (w_coeffs[r_k]),
        .o_acc   (w_acc)
    );

    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;

endmodule

// File: tb/tb_sym_odd_fir_serial_ctrl.sv
// Four filter instances (N_COEFFS 1, 3, 5 default, 8) share one input
// stream; each result is compared against a direct-form full-length FIR
// computed from the sample history.
module tb_sym_odd_fir_serial_ctrl;

    localparam logic [4:0]  C1 = 5'b10101;                                   // -11
    localparam logic [14:0] C3 = {5'b11101, 5'b01111, 5'b10000};             // -16,15,-3
    localparam logic [39:0] C8 = {5'd9, 5'd0, 5'b11111, 5'd15,
                                  5'b10000, 5'd12, 5'b11001, 5'd3};          // 3,-7,12,-16,15,-1,0,9

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [15:0] data_in = '0;
    logic valid_in = 1'b0;
    logic rdy [4];
    logic vo  [4];
    logic bsy [4];
    logic signed [21:0] do1;
    logic signed [23:0] do3;
    logic signed [24:0] do5;
    logic signed [24:0] do8;

    always #5 clk = ~clk;

    sym_odd_fir_serial_ctrl #(.N_COEFFS(1), .COEFFS(C1)) u1 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy[0]), .data_out(do1), .valid_out(vo[0]), .busy(bsy[0]));
    sym_odd_fir_serial_ctrl #(.N_COEFFS(3), .COEFFS(C3)) u3 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy[1]), .data_out(do3), .valid_out(vo[1]), .busy(bsy[1]));
    sym_odd_fir_serial_ctrl dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy[2]), .data_out(do5), .valid_out(vo[2]), .busy(bsy[2]));
    sym_odd_fir_serial_ctrl #(.N_COEFFS(8), .COEFFS(C8)) u8 (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_in(rdy[3]), .data_out(do8), .valid_out(vo[3]), .busy(bsy[3]));

    int     n_tests = 0;
    int     n_fail  = 0;
    int     nc [4]  = '{1, 3, 5, 8};
    int     cf [4][8];
    int     hist [$];
    longint got [4];
    bit     gotf [4];

    function automatic longint obs(input int idx);
        case (idx)
            0:       return longint'(do1);
            1:       return longint'(do3);
            2:       return longint'(do5);
            default: return longint'(do8);
        endcase
    endfunction

    // Direct-form FIR of length 2n-1 with mirrored impulse response.
    function automatic longint ref_y(input int idx);
        longint acc = 0;
        longint x;
        int n = nc[idx];
        int len = 2*n - 1;
        for (int j = 0; j < len; j++) begin
            x = (j < hist.size()) ? longint'(hist[hist.size()-1-j]) : 0;
            acc += x * longint'(cf[idx][(j < n) ? j : len-1-j]);
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input longint o, input longint e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        chk("rst_ready",    longint'(rdy[2]), 1);
        chk("rst_valid",    longint'(vo[2]), 0);
        chk("rst_busy",     longint'(bsy[2]), 0);
        chk("rst_data_out", longint'(do5), 0);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic send(input logic signed [15:0] s);
        int t = 0;
        @(negedge clk);
        while (!(rdy[0] && rdy[1] && rdy[2] && rdy[3]) && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", longint'(t < 40), 1);
        data_in  = s;
        valid_in = 1'b1;
        hist.push_back(int'(s));
        if (hist.size() > 20) void'(hist.pop_front());
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) gotf[i] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < 4; i++)
                if (vo[i] && !gotf[i]) begin
                    gotf[i] = 1'b1;
                    got[i]  = obs(i);
                end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("valid_seen_n%0d", nc[i]), longint'(gotf[i]), 1);
            chk($sformatf("y_n%0d", nc[i]), got[i], ref_y(i));
        end
    endtask

    int  exp_imp  [10] = '{1, 6, 0, 0, 0, 0, 0, 6, 1, 0};
    int  exp_step [11] = '{100, 700, 700, 700, 700, 700, 700, 1300, 1400, 1400, 1400};
    bit  r_a [42];
    bit  v_a [42];
    int  cnt;
    bit  seen;

    initial begin
        cf[0] = '{-11, 0, 0, 0, 0, 0, 0, 0};
        cf[1] = '{-16, 15, -3, 0, 0, 0, 0, 0};
        cf[2] = '{1, 6, 0, 0, 0, 0, 0, 0};
        cf[3] = '{3, -7, 12, -16, 15, -1, 0, 9};

        // impulse
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0);
            chk($sformatf("impulse_%0d", i), got[2], exp_imp[i]);
        end

        // step
        do_reset();
        for (int i = 0; i < 11; i++) begin
            send(16'sd100);
            chk($sformatf("step_%0d", i), got[2], exp_step[i]);
        end

        // negative full scale
        do_reset();
        for (int i = 0; i < 12; i++) send(-16'sd32768);
        chk("neg_full_scale", got[2], -458752);

        // throughput with valid_in held high
        do_reset();
        data_in  = 16'sd50;
        valid_in = 1'b1;
        for (int i = 0; i < 42; i++) begin
            r_a[i] = rdy[2];
            v_a[i] = vo[2];
            @(negedge clk);
        end
        valid_in = 1'b0;
        cnt = 0;
        for (int i = 0; i < 35; i++) begin
            chk($sformatf("thru_valid_%0d", i), longint'(v_a[i+7]), longint'(r_a[i]));
            cnt += int'(r_a[i]);
        end
        chk("thru_accepts", cnt, 5);

        // reset in the third MAC cycle, then impulse
        do_reset();
        for (int i = 0; i < 3; i++) send(16'(1000 + 37*i));
        @(negedge clk);
        data_in  = 16'sd777;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hist.delete();
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (vo[2]) seen = 1'b1;
            @(negedge clk);
        end
        chk("no_stray_valid", longint'(seen), 0);
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0);
            chk($sformatf("impulse_after_rst_%0d", i), got[2], exp_imp[i]);
        end

        // random stream, corners sprinkled in
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if (k % 16 == 3)       send(-16'sd32768);
            else if (k % 16 == 9)  send(16'sh7fff);
            else                   send(16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
